// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one simple dual-port BRAM (1-cycle registered read) between A and B.
// Define BRAM_ARB_CLEAR_EN to zero the whole RAM after every reset before accepting commands.
module bram_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,

    output logic              busy
);

    localparam logic GrantA = 1'b0;
    localparam logic GrantB = 1'b1;

    logic last_grant_q, last_grant_d;
    logic a_rd_q, a_rd_d;
    logic b_rd_q, b_rd_d;
    logic run;
    logic grant_a, grant_b;

`ifdef BRAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Counter stops at the top address; leaving CLEAR never relies on it wrapping.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = StRun;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    assign run  = (state_q == StRun);
    assign busy = ~run;
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GrantB;
            a_rd_q       <= 1'b0;
            b_rd_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            a_rd_q       <= a_rd_d;
            b_rd_q       <= b_rd_d;
        end
    end

    always_comb begin
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        last_grant_d = last_grant_q;
        mem_w_en     = 1'b0;
        mem_w_addr   = a_addr;
        mem_w_data   = a_wdata;
        mem_r_en     = 1'b0;
        mem_r_addr   = a_addr;

        // A wins unless B also wants the port and A had the previous grant.
        if (run) begin
            if (a_valid && (!b_valid || last_grant_q == GrantB)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end

        if (grant_b) begin
            mem_w_addr = b_addr;
            mem_w_data = b_wdata;
            mem_r_addr = b_addr;
        end

        if (grant_a || grant_b) begin
            last_grant_d = grant_b ? GrantB : GrantA;
            mem_w_en     = grant_a ? a_we : b_we;
            mem_r_en     = grant_a ? ~a_we : ~b_we;
        end

`ifdef BRAM_ARB_CLEAR_EN
        if (state_q == StClear) begin
            mem_w_en   = 1'b1;
            mem_w_addr = clr_cnt_q;
            mem_w_data = '0;
        end
`endif

        a_rd_d = grant_a & ~a_we;
        b_rd_d = grant_b & ~b_we;
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = a_rd_q;
    assign b_rvalid = b_rd_q;
    assign a_rdata  = mem_r_data;
    assign b_rdata  = mem_r_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: behavioural BRAM, expected-read scoreboard, per-cycle port checks.
module tb_bram_arbiter;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_w_en, mem_r_en, busy;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic          who;  // 0 = A, 1 = B
        logic [DW-1:0] data;
    } resp_t;

    resp_t         sb[$];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] ram [DEPTH];
    logic          ram_init;

    always #5 clk = ~clk;

    bram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_w_en  (mem_w_en),
        .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data),
        .mem_r_en  (mem_r_en),
        .mem_r_addr(mem_r_addr),
        .mem_r_data(mem_r_data),
        .busy      (busy)
    );

    // Behavioural RAM; pre-filled with 0xFF when the clear sweep is expected to wipe it.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef BRAM_ARB_CLEAR_EN
                ram[i] <= 8'hFF;
`else
                ram[i] <= 8'h00;
`endif
            end
        end else begin
            if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
            if (mem_r_en) mem_r_data <= ram[mem_r_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven; check grants and RAM ports, update model, advance.
    task automatic step(input string tag, input logic ga, input logic gb, input bit resp);
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        resp_t         r;
        @(negedge clk);
        check({tag, ".a_ready"}, 32'(a_ready), 32'(ga));
        check({tag, ".b_ready"}, 32'(b_ready), 32'(gb));
        we   = ga ? a_we : b_we;
        addr = ga ? a_addr : b_addr;
        wd   = ga ? a_wdata : b_wdata;
        check({tag, ".mem_w_en"}, 32'(mem_w_en), 32'((ga | gb) & we));
        check({tag, ".mem_r_en"}, 32'(mem_r_en), 32'((ga | gb) & ~we));
        if (ga | gb) begin
            if (we) begin
                check({tag, ".mem_w_addr"}, 32'(mem_w_addr), 32'(addr));
                check({tag, ".mem_w_data"}, 32'(mem_w_data), 32'(wd));
                exp_mem[addr] = wd;
            end else begin
                check({tag, ".mem_r_addr"}, 32'(mem_r_addr), 32'(addr));
                if (resp) begin
                    r.who  = gb;
                    r.data = exp_mem[addr];
                    sb.push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    // Response monitor: every read handshake must answer exactly one cycle later.
    always begin
        resp_t e;
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp.rvalid", 32'({a_rvalid, b_rvalid}), e.who ? 32'h1 : 32'h2);
            check("resp.rdata", e.who ? 32'(b_rdata) : 32'(a_rdata), 32'(e.data));
        end else begin
            check("idle.rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
        end
    end

    initial begin
        reset    = 1'b1;
        ram_init = 1'b1;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;

        @(negedge clk);
        check("rst.a_ready", 32'(a_ready), 32'h0);
        check("rst.b_ready", 32'(b_ready), 32'h0);
        check("rst.rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
`ifdef BRAM_ARB_CLEAR_EN
        check("rst.busy", 32'(busy), 32'h1);
`else
        check("rst.busy", 32'(busy), 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef BRAM_ARB_CLEAR_EN
        // Requests held during the sweep must be ignored.
        drive_a(1'b1, 1'b0, 9'h1FF, 8'h00);
        drive_b(1'b1, 1'b1, 9'h0AA, 8'h55);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("clear[%0d]", i),
                  {11'h0, busy, mem_w_en, mem_w_addr, mem_w_data, mem_r_en, a_ready, b_ready},
                  {11'h0, 1'b1, 1'b1, 9'(i), 8'h00, 1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
`endif
        @(negedge clk);
        check("run.busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;

        // Contention from reset: A first, then strict alternation.
        drive_a(1'b1, 1'b0, 9'h001, 8'h00);
        drive_b(1'b1, 1'b0, 9'h002, 8'h00);
        step("cont0", 1'b1, 1'b0, 1'b1);
        step("cont1", 1'b0, 1'b1, 1'b1);
        step("cont2", 1'b1, 1'b0, 1'b1);
        step("cont3", 1'b0, 1'b1, 1'b1);
        drive_b(1'b0, 1'b0, '0, '0);

        drive_a(1'b1, 1'b0, 9'h1FF, 8'h00);
        step("rd1ff", 1'b1, 1'b0, 1'b1);

        drive_a(1'b1, 1'b1, 9'h010, 8'hA5);
        step("wr010", 1'b1, 1'b0, 1'b1);
        drive_a(1'b1, 1'b0, 9'h010, 8'h00);
        step("rd010", 1'b1, 1'b0, 1'b1);
        drive_a(1'b0, 1'b0, '0, '0);

        drive_b(1'b1, 1'b1, 9'h020, 8'h3C);
        step("raw.wr", 1'b0, 1'b1, 1'b1);
        drive_b(1'b0, 1'b0, '0, '0);
        drive_a(1'b1, 1'b0, 9'h020, 8'h00);
        step("raw.rd", 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b1, 9'(i), 8'(8'h40 + i));
            step($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b1);
        end
        drive_a(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            drive_b(1'b1, 1'b0, 9'(i), 8'h00);
            step($sformatf("stream%0d", i), 1'b0, 1'b1, 1'b1);
        end
        drive_b(1'b0, 1'b0, '0, '0);
        step("idle", 1'b0, 1'b0, 1'b1);
        step("idle2", 1'b0, 1'b0, 1'b1);

        // Read granted in the cycle whose closing edge samples reset: no response allowed.
        drive_a(1'b1, 1'b0, 9'h005, 8'h00);
        reset = 1'b1;
        step("midrst", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        drive_a(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
`ifdef BRAM_ARB_CLEAR_EN
            check($sformatf("resweep[%0d]", i), 32'({busy, mem_w_en, mem_w_addr}),
                  32'({1'b1, 1'b1, 9'(i)}));
`else
            check($sformatf("postrst[%0d]", i), 32'({busy, mem_w_en, mem_r_en}), 32'h0);
`endif
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester, single-clock arbiter that shares one simple dual-port block RAM (separate write and read ports, 1-cycle registered read) between requesters A and B.
- Each requester gets a valid/ready command channel and a read-response channel.
- Sits between client logic (e.g. framebuffer writer and display reader) and the memory instance.
- Wire the RAM's r_clk and w_clk to this block's clk.

Parameters:
- ADDR_W, 9, RAM address width; depth = 2^ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  single clock; also drives both RAM clocks.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  A command valid.
- a_ready  out  1  A command accepted this cycle.
- a_we  in  1  A command is a write (1) or read (0).
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as the A ports, for B.
- mem_w_en  out  1  RAM write enable.
- mem_w_addr  out  ADDR_W  RAM write address.
- mem_w_data  out  DATA_W  RAM write data.
- mem_r_en  out  1  RAM read enable.
- mem_r_addr  out  ADDR_W  RAM read address.
- mem_r_data  in  DATA_W  RAM registered read data.
- busy  out  1  arbiter not accepting commands (clear sweep in progress).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: a_ready=b_ready=0, a_rvalid=b_rvalid=0, busy per Optional Feature, last_grant=B (so A wins the first contention).
- Mid-operation reset: pending read tags are cleared and no rvalid fires afterwards; a RAM write in flight on that edge is not guaranteed.
- States: CLEAR (feature only) and RUN.
- Grant in RUN (combinational, at most one grant per cycle):
  - only A valid -> grant A; only B valid -> grant B;
  - both valid -> grant the requester that is not last_grant.
- x_ready = grant to x; a handshake is valid && ready in the same cycle.
- last_grant updates to the granted requester on every grant; it holds when there is no grant.
- Write grant: mem_w_en=1, mem_w_addr/mem_w_data from the winner, same cycle; no response is generated.
- Read grant: mem_r_en=1, mem_r_addr from the winner, same cycle.
  - A registered tag is set; next cycle x_rvalid=1 for exactly one cycle and x_rdata=mem_r_data.
  - Read latency is 1 cycle, fixed. Responses have no backpressure.
- x_rdata is don't-care while x_rvalid=0. The bench must check it only when rvalid=1.
- mem_w_en and mem_r_en are 0 whenever there is no corresponding grant. Addr/data are don't-care then.
- Back-to-back: one requester held valid alone is granted every cycle (full throughput).
- Under continuous contention the grants strictly alternate A, B, A, B...
- Read-after-write:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
  - A read and a write are never issued in the same cycle, so there is no same-cycle collision.
- Inputs must be stable while valid=1 && ready=0. Requesters may drop valid without a handshake.

Optional Feature:
- Macro: BRAM_ARB_CLEAR_EN.
- Enabled:
  - Reset enters CLEAR with busy=1 and an ADDR_W-bit clear counter at 0.
  - Each cycle: mem_w_en=1, mem_w_addr=counter, mem_w_data=0, counter+1.
  - After writing address 2^ADDR_W-1, the next cycle enters RUN with busy=0; no counter wrap is used.
  - In CLEAR: a_ready=b_ready=0 and mem_r_en=0.
  - Reset asserted during CLEAR restarts the sweep from address 0.
- Disabled: no CLEAR state; reset goes directly to RUN; busy is tied 0.

Test Plan:
- Clear sweep (feature on, ADDR_W=9): release reset -> busy=1 for exactly 512 cycles, mem_w_en=1 with addresses 0..511 and data 0; then busy=0, and an A read of 0x1FF returns 0x00.
- Single write/read: A writes addr 0x010 data 0xA5 (granted same cycle); next cycle A reads 0x010 -> a_rvalid one cycle later with a_rdata=0xA5, b_rvalid stays 0.
- Contention: A and B both hold valid reads (0x001, 0x002) for 4 cycles after reset -> grants A,B,A,B; rvalid alternates a,b,a,b one cycle later.
- Read-after-write, two requesters: B writes 0x020=0x3C in cycle N; A reads 0x020 in cycle N+1 -> a_rdata=0x3C.
- Stream: B alone issues reads of 0x000..0x007 every cycle -> b_ready=1 every cycle, 8 consecutive b_rvalid pulses carrying the data in order.
- Mid-read reset: A read granted, reset asserted next edge -> a_rvalid never asserts; with the feature on, busy=1 and the sweep restarts at address 0.
